// File: rtl/fpu_responder.sv
// fpu_responder
//   FPU-side end of the arbiter-to-FPU link. An op code and two operands
//   arrive over one 32-bit bus (A in the start cycle, B in the next cycle).
//   The op runs, and a registered result comes back with a one-cycle done pulse.
//   Supported ops: single-precision FMUL, FMIN, FMAX, FABS, FNEG and FSGNJ.
//   FMUL is an iterative shift-add multiplier. It rounds toward zero and
//   flushes subnormals to zero.
//
// Parameters
//   BITS_PER_CYCLE  multiplier bits retired per MUL_ITER cycle (1, 2, 4, 8)
//   CANON_NAN       value returned for every NaN result and for reserved ops
//
// Ports
//   clock      in   1   rising-edge clock
//   reset      in   1   asynchronous active-high reset
//   io_op      in   3   0 idle, 1 FMUL, 2 FMIN, 3 FMAX, 4 FABS, 5 FNEG,
//                       6 FSGNJ, 7 reserved
//   io_ab      in  32   operand A in the start cycle, operand B in the next
//   io_result  out 32   registered result, held until the next write
//   io_done    out  1   one-cycle pulse in the cycle after io_result updates
//   io_busy    out  1   operation in progress (EXEC through DONE)
module fpu_responder #(
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter logic [31:0] CANON_NAN      = 32'h7FC00000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  io_op,
    input  logic [31:0] io_ab,
    output logic [31:0] io_result,
    output logic        io_done,
    output logic        io_busy
);

    localparam int unsigned ITERS      = 24 / BITS_PER_CYCLE;
    localparam logic [4:0]  ITERS_INIT = 5'(ITERS);

    localparam logic [2:0] OP_FMUL  = 3'd1;
    localparam logic [2:0] OP_FMIN  = 3'd2;
    localparam logic [2:0] OP_FMAX  = 3'd3;
    localparam logic [2:0] OP_FABS  = 3'd4;
    localparam logic [2:0] OP_FNEG  = 3'd5;
    localparam logic [2:0] OP_FSGNJ = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_B,
        ST_EXEC,
        ST_MUL_ITER,
        ST_NORM,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [2:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [47:0]        r_ma;     // multiplicand, shifted left as bits retire
    logic [23:0]        r_mb;     // multiplier, shifted right as bits retire
    logic [47:0]        r_acc;
    logic [4:0]         r_cnt;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [31:0]        r_result;

    // Operand field decode
    logic        w_a_sign, w_b_sign;
    logic [7:0]  w_a_exp,  w_b_exp;
    logic [22:0] w_a_frac, w_b_frac;
    logic        w_a_nan,  w_b_nan;
    logic        w_a_inf,  w_b_inf;
    logic        w_a_zero, w_b_zero;

    assign w_a_sign = r_a[31];
    assign w_b_sign = r_b[31];
    assign w_a_exp  = r_a[30:23];
    assign w_b_exp  = r_b[30:23];
    assign w_a_frac = r_a[22:0];
    assign w_b_frac = r_b[22:0];
    assign w_a_nan  = (w_a_exp == 8'hFF) && (w_a_frac != '0);
    assign w_b_nan  = (w_b_exp == 8'hFF) && (w_b_frac != '0);
    assign w_a_inf  = (w_a_exp == 8'hFF) && (w_a_frac == '0);
    assign w_b_inf  = (w_b_exp == 8'hFF) && (w_b_frac == '0);
    // Subnormals are flushed, so any zero exponent counts as zero
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);

    // FMUL special-case detection and result
    logic              w_mul_sign;
    logic              w_mul_special;
    logic [31:0]       w_mul_special_res;
    logic signed [9:0] w_exp_sum;

    assign w_mul_sign = w_a_sign ^ w_b_sign;
    assign w_exp_sum  = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - 10'sd127;

    always_comb begin
        w_mul_special     = 1'b1;
        w_mul_special_res = '0;
        if (w_a_nan || w_b_nan) begin
            w_mul_special_res = CANON_NAN;
        end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_mul_special_res = CANON_NAN;
        end else if (w_a_inf || w_b_inf) begin
            w_mul_special_res = {w_mul_sign, 8'hFF, 23'd0};
        end else if (w_a_zero || w_b_zero) begin
            w_mul_special_res = {w_mul_sign, 31'd0};
        end else begin
            w_mul_special     = 1'b0;
        end
    end

    // Total order for FMIN/FMAX. Map each value to an unsigned key: negatives
    // are inverted and positives get the sign bit flipped. With this mapping
    // -0 sorts just below +0.
    logic [31:0] w_a_key, w_b_key;
    logic        w_a_lt_b;

    assign w_a_key  = w_a_sign ? ~r_a : (r_a ^ 32'h80000000);
    assign w_b_key  = w_b_sign ? ~r_b : (r_b ^ 32'h80000000);
    assign w_a_lt_b = (w_a_key < w_b_key);

    logic [31:0] w_min_res, w_max_res;

    always_comb begin
        w_min_res = '0;
        w_max_res = '0;
        if (w_a_nan && w_b_nan) begin
            w_min_res = CANON_NAN;
            w_max_res = CANON_NAN;
        end else if (w_a_nan) begin
            w_min_res = r_b;
            w_max_res = r_b;
        end else if (w_b_nan) begin
            w_min_res = r_a;
            w_max_res = r_a;
        end else begin
            w_min_res = w_a_lt_b ? r_a : r_b;
            w_max_res = w_a_lt_b ? r_b : r_a;
        end
    end

    // Result written in EXEC for everything except a normal FMUL
    logic [31:0] w_exec_result;
    logic        w_exec_mul_normal;

    assign w_exec_mul_normal = (r_op == OP_FMUL) && !w_mul_special;

    always_comb begin
        w_exec_result = CANON_NAN;
        case (r_op)
            OP_FMUL:  w_exec_result = w_mul_special_res;
            OP_FMIN:  w_exec_result = w_min_res;
            OP_FMAX:  w_exec_result = w_max_res;
            OP_FABS:  w_exec_result = {1'b0, r_a[30:0]};
            OP_FNEG:  w_exec_result = {~r_a[31], r_a[30:0]};
            OP_FSGNJ: w_exec_result = {r_b[31], r_a[30:0]};
            default:  w_exec_result = CANON_NAN;
        endcase
    end

    // Shift-add step: add the multiplicand once for each set bit among the
    // BITS_PER_CYCLE low multiplier bits, weighted by the bit position.
    logic [47:0] w_partial;

    always_comb begin
        w_partial = '0;
        for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_mb[j]) begin
                w_partial = w_partial + (r_ma << j);
            end
        end
    end

    // Normalisation, plus exponent overflow and underflow handling
    logic signed [9:0] w_norm_exp;
    logic [22:0]       w_norm_mant;
    logic [31:0]       w_norm_result;

    assign w_norm_exp  = r_exp + (r_acc[47] ? 10'sd1 : 10'sd0);
    assign w_norm_mant = r_acc[47] ? r_acc[46:24] : r_acc[45:23];

    always_comb begin
        w_norm_result = {r_sign, w_norm_exp[7:0], w_norm_mant};
        if (w_norm_exp >= 10'sd255) begin
            w_norm_result = {r_sign, 8'hFF, 23'd0};
        end else if (w_norm_exp <= 10'sd0) begin
            w_norm_result = {r_sign, 31'd0};
        end
    end

    // Truncated product bits and the exponent's range bits are not needed in the result
    logic w_unused_bits;
    assign w_unused_bits = ^{r_acc[22:0], w_norm_exp[9:8]};

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and status outputs. io_busy is held low in GET_B, so busy
    // rises on the edge after the start edge and falls on the edge that
    // leaves DONE.
    always_comb begin
        w_state_next = r_state;
        io_done      = 1'b0;
        io_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_op != '0) w_state_next = ST_GET_B;
            end
            ST_GET_B: begin
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                io_busy      = 1'b1;
                w_state_next = w_exec_mul_normal ? ST_MUL_ITER : ST_DONE;
            end
            ST_MUL_ITER: begin
                io_busy = 1'b1;
                if (r_cnt == 5'd1) w_state_next = ST_NORM;
            end
            ST_NORM: begin
                io_busy      = 1'b1;
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                io_busy      = 1'b1;
                io_done      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_op != '0) begin
                        r_op <= io_op;
                        r_a  <= io_ab;
                    end
                end
                ST_GET_B: begin
                    r_b <= io_ab;
                end
                ST_EXEC: begin
                    if (w_exec_mul_normal) begin
                        r_ma   <= {24'd0, 1'b1, w_a_frac};
                        r_mb   <= {1'b1, w_b_frac};
                        r_acc  <= '0;
                        r_cnt  <= ITERS_INIT;
                        r_sign <= w_mul_sign;
                        r_exp  <= w_exp_sum;
                    end else begin
                        r_result <= w_exec_result;
                    end
                end
                ST_MUL_ITER: begin
                    r_acc <= r_acc + w_partial;
                    r_ma  <= r_ma << BITS_PER_CYCLE;
                    r_mb  <= r_mb >> BITS_PER_CYCLE;
                    r_cnt <= r_cnt - 5'd1;
                end
                ST_NORM: begin
                    r_result <= w_norm_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign io_result = r_result;

endmodule

// File: tb/tb_fpu_responder.sv
module tb_fpu_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  io_op;
    logic [31:0] io_ab;
    logic [31:0] res1, res4;
    logic        done1, done4;
    logic        busy1, busy4;

    always #5 clock = ~clock;

    fpu_responder #(.BITS_PER_CYCLE(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .io_op     (io_op),
        .io_ab     (io_ab),
        .io_result (res1),
        .io_done   (done1),
        .io_busy   (busy1)
    );

    fpu_responder #(.BITS_PER_CYCLE(4)) dut4 (
        .clock     (clock),
        .reset     (reset),
        .io_op     (io_op),
        .io_ab     (io_ab),
        .io_result (res4),
        .io_done   (done4),
        .io_busy   (busy4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) until both instances are idle
    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy1 && !busy4) break;
            @(negedge clock);
        end
        check_int("idle_wait", int'(busy1 | busy4), 0);
        repeat (2) @(negedge clock);
    endtask

    // Issue one op and watch the selected instance. Edges are numbered from
    // the start edge (edge 1). Outputs are sampled 1 time unit after each edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit use4, output int done_edge, output int n_done,
                          output int n_busy, output logic [31:0] res);
        logic d, bz;
        done_edge = -1;
        n_done    = 0;
        n_busy    = 0;
        res       = '0;
        @(negedge clock);
        io_op = op;
        io_ab = a;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clock);
            #1;
            if (e == 1) begin
                io_op = '0;
                io_ab = b;
            end
            d  = use4 ? done4 : done1;
            bz = use4 ? busy4 : busy1;
            if (bz) n_busy++;
            if (d) begin
                n_done++;
                if (done_edge < 0) begin
                    done_edge = e;
                    res       = use4 ? res4 : res1;
                end
            end
            if (done_edge > 0 && e >= done_edge + 2) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          de, nd, nb, cnt;
        logic [31:0] r;
        int          edges[3];
        logic [31:0] rs[3];

        reset = 1'b1;
        io_op = '0;
        io_ab = '0;

        // FMUL normal path latency at BITS_PER_CYCLE=1 is 4+24 = 28
        add(3'd1, 32'h40000000, 32'h40400000, 32'h40C00000, 28);
        add(3'd1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 28);
        add(3'd1, 32'hC0000000, 32'h40400000, 32'hC0C00000, 28);
        add(3'd1, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 28);
        add(3'd1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 28);
        add(3'd1, 32'h7F000000, 32'h3F800000, 32'h7F000000, 28);
        add(3'd1, 32'h7F000000, 32'h40000000, 32'h7F800000, 28);
        add(3'd1, 32'h00800000, 32'h3F000000, 32'h00000000, 28);
        add(3'd1, 32'h80800000, 32'h3F800000, 32'h80800000, 28);
        add(3'd1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 3);
        add(3'd1, 32'h7F800000, 32'hBF800000, 32'hFF800000, 3);
        add(3'd1, 32'h80400000, 32'h3F800000, 32'h80000000, 3);
        add(3'd1, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 3);
        add(3'd2, 32'h80000000, 32'h00000000, 32'h80000000, 3);
        add(3'd2, 32'h00000000, 32'h80000000, 32'h80000000, 3);
        add(3'd3, 32'h80000000, 32'h00000000, 32'h00000000, 3);
        add(3'd3, 32'h7FC00001, 32'h3F800000, 32'h3F800000, 3);
        add(3'd2, 32'h3F800000, 32'hFFC00000, 32'h3F800000, 3);
        add(3'd2, 32'h7FC00000, 32'h7F800001, 32'h7FC00000, 3);
        add(3'd2, 32'hC0000000, 32'hBF800000, 32'hC0000000, 3);
        add(3'd3, 32'hC0000000, 32'hBF800000, 32'hBF800000, 3);
        add(3'd3, 32'h7F800000, 32'h40000000, 32'h7F800000, 3);
        add(3'd6, 32'h3F800000, 32'h80000000, 32'hBF800000, 3);
        add(3'd4, 32'hFFC12345, 32'h00000000, 32'h7FC12345, 3);
        add(3'd5, 32'h00000000, 32'h12345678, 32'h80000000, 3);
        add(3'd5, 32'h7FC00001, 32'h00000000, 32'hFFC00001, 3);
        add(3'd7, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 3);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check32("reset_result", res1, 32'h0);
        check_int("reset_done", int'(done1), 0);
        check_int("reset_busy", int'(busy1), 0);
        @(negedge clock);
        reset = 1'b0;

        // Table-driven vectors on the BITS_PER_CYCLE=1 instance
        foreach (vecs[i]) begin
            wait_idle();
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, de, nd, nb, r);
            check32($sformatf("vec%0d_result", i), r, vecs[i].exp);
            check_int($sformatf("vec%0d_done_edge", i), de, vecs[i].lat);
            check_int($sformatf("vec%0d_done_pulses", i), nd, 1);
            check_int($sformatf("vec%0d_busy_cycles", i), nb, vecs[i].lat - 1);
        end

        // BITS_PER_CYCLE=4: latency 4+6 = 10
        wait_idle();
        run_op(3'd1, 32'h3FC00000, 32'h3FC00000, 1'b1, de, nd, nb, r);
        check32("bpc4_result", r, 32'h40100000);
        check_int("bpc4_done_edge", de, 10);
        check_int("bpc4_busy_cycles", nb, 9);

        // Reset during MUL_ITER (after 10 iterations)
        wait_idle();
        check_int("pre_reset_result_nonzero", int'(res1 != 32'h0), 1);
        @(negedge clock);
        io_op = 3'd1;
        io_ab = 32'h40000000;
        @(posedge clock);
        #1;
        io_op = '0;
        io_ab = 32'h40400000;
        repeat (12) @(posedge clock);
        #1;
        check_int("midmul_busy_before_reset", int'(busy1), 1);
        reset = 1'b1;
        #1;
        check_int("async_reset_done", int'(done1), 0);
        check_int("async_reset_busy", int'(busy1), 0);
        check32("async_reset_result", res1, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        cnt = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clock);
            #1;
            if (done1) cnt++;
        end
        check_int("no_done_after_reset", cnt, 0);
        run_op(3'd4, 32'hC0000000, 32'h00000000, 1'b0, de, nd, nb, r);
        check32("post_reset_fabs_result", r, 32'h40000000);
        check_int("post_reset_fabs_edge", de, 3);

        // Held io_op=5: restarts after one IDLE sampling cycle
        wait_idle();
        @(negedge clock);
        io_op = 3'd5;
        io_ab = 32'h3F800000;
        cnt = 0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clock);
            #1;
            if (e == 10) io_op = '0;
            if (done1) begin
                if (cnt < 3) begin
                    edges[cnt] = e;
                    rs[cnt]    = res1;
                end
                cnt++;
            end
        end
        check_int("b2b_pulses", cnt, 3);
        if (cnt >= 3) begin
            check_int("b2b_edge0", edges[0], 3);
            check_int("b2b_edge1", edges[1], 7);
            check_int("b2b_edge2", edges[2], 11);
            for (int k = 0; k < 3; k++) begin
                check32($sformatf("b2b_result%0d", k), rs[k], 32'hBF800000);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
